// File: rtl/spi_adc_pkg.sv
// -----------------------------------------------------------------------------
// spi_adc_pkg
//   Shared definitions for the serial ADC pair (spi_master_adc / spi_slave_adc):
//   default frame geometry and the responder FSM state encoding.
// -----------------------------------------------------------------------------
package spi_adc_pkg;

  // Converter frame geometry: LEAD zeros, DATA bits MSB first, trailing zeros.
  localparam int DEF_LEAD_ZEROS = 3;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } adc_state_e;

endpackage : spi_adc_pkg

// File: rtl/spi_slave_adc_if.sv
// -----------------------------------------------------------------------------
// spi_slave_adc_if
//   Three-wire serial ADC bus between spi_master_adc and the converter.
//   Signals:
//     sclk  - serial clock, driven by the master
//     cs_n  - chip select, active low, driven by the master
//     sdata - serial data, driven by the converter, MSB first
//   Modports: master (drives sclk/cs_n), slave (drives sdata).
// -----------------------------------------------------------------------------
interface spi_slave_adc_if;
  logic sclk;
  logic cs_n;
  logic sdata;

  modport master (output sclk, output cs_n, input  sdata);
  modport slave  (input  sclk, input  cs_n, output sdata);
endinterface : spi_slave_adc_if

// File: rtl/spi_slave_adc_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Two-flop synchronizer for one asynchronous input, followed by a third
//   register used for edge detection.
//   Ports:
//     clk, rst  - system clock, asynchronous active-high reset
//     async_i   - asynchronous input pin
//     level_o   - synchronized level
//     rise_o    - one-cycle pulse on a synchronized 0->1 transition
//     fall_o    - one-cycle pulse on a synchronized 1->0 transition
//   All three stages reset to RST_VAL so no edge is reported out of reset
//   while the pin sits at its idle level.
// -----------------------------------------------------------------------------
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  =  sync_q & ~prev_q;
  assign fall_o  = ~sync_q &  prev_q;

endmodule : sync_edge

// File: rtl/spi_slave_adc.sv
// -----------------------------------------------------------------------------
// spi_slave_adc
//   Responder-side model of the 8-bit serial ADC read by spi_master_adc.
//   One sample is returned per chip-select frame as LEAD_ZEROS zeros, the
//   sample MSB first, then trailing zeros. sdata changes on falling sclk; the
//   master samples on rising sclk.
//   Ports:
//     clk, rst    - 50 MHz system clock, asynchronous active-high reset
//     spi         - slave modport of spi_slave_adc_if (sclk, cs_n in; sdata out)
//     sample_in   - value returned in the next frame, latched at frame start
//     busy        - high while a frame is active
//     frame_done  - one-cycle pulse at the end of every frame
//     frame_err   - sticky short-frame flag, cleared only by rst
//     frame_cnt   - count of good frames, wraps 255 -> 0
//   Build option:
//     SPI_ADC_RAMP_EN - ignore sample_in; return an internal ramp that starts
//                       at 0 and advances by one on every good frame.
//   All outputs are registered; pin-to-output latency is 3 clk cycles.
// -----------------------------------------------------------------------------
module spi_slave_adc
  import spi_adc_pkg::*;
#(
  parameter int LEAD_ZEROS = DEF_LEAD_ZEROS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_slave_adc_if.slave       spi,
  input  logic [DATA_BITS-1:0] sample_in,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [7:0]           frame_cnt
);

  localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
  localparam int IDX_W       = $clog2(FRAME_BITS);
  localparam int CNT_W       = $clog2(FRAME_BITS + 1);

  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FALL_MAX = CNT_W'(FRAME_BITS);
  // A frame whose final sclk fall races cs_n rising is still accepted.
  localparam logic [CNT_W-1:0] GOOD_MIN = CNT_W'(FRAME_BITS - 1);

  // Bit k of the frame: place the sample inside the zero-padded frame word,
  // then shift bit k up to the MSB position.
  function automatic logic frame_bit(input logic [DATA_BITS-1:0] s,
                                     input logic [IDX_W-1:0]     k);
    logic [FRAME_BITS-1:0] word;
    word = FRAME_BITS'(s) << TRAIL_ZEROS;
    word = word << k;
    return word[FRAME_BITS-1];
  endfunction

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (spi.cs_n),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (spi.sclk),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // The master samples on rising sclk; only falls matter here.
  logic unused_sclk;
  assign unused_sclk = sclk_lvl ^ sclk_rise;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  adc_state_e           state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]     fall_cnt_q, fall_cnt_d;
  logic                 sdata_q, sdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 pend_q, pend_d;     // cs_fall seen while in DONE
  logic [1:0]           ready_q;            // sync chain refilled after reset
  logic                 armed_q;            // cs_n seen high since reset
  logic [IDX_W-1:0]     idx_next;
  logic [DATA_BITS-1:0] load_val;

`ifdef SPI_ADC_RAMP_EN
  logic [DATA_BITS-1:0] ramp_q, ramp_d;
  logic                 unused_sample;
  assign unused_sample = ^sample_in;
  assign load_val      = ramp_q;
`else
  assign load_val      = sample_in;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    fall_cnt_d = fall_cnt_q;
    sdata_d    = sdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
`ifdef SPI_ADC_RAMP_EN
    ramp_d     = ramp_q;
`endif
    idx_next   = (bit_idx_q == IDX_MAX) ? bit_idx_q : bit_idx_q + IDX_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        // A falling cs_n that landed during DONE is honoured one cycle late.
        if (armed_q && (cs_fall || pend_q)) begin
          state_d    = ST_ACTIVE;
          shreg_d    = load_val;
          bit_idx_d  = '0;
          fall_cnt_d = '0;
          sdata_d    = frame_bit(load_val, '0);
          busy_d     = 1'b1;
          pend_d     = 1'b0;
        end
      end

      ST_ACTIVE: begin
        // cs_rise has priority: a coincident sclk fall is not counted.
        if (cs_rise) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          sdata_d = 1'b0;
          if (fall_cnt_q >= GOOD_MIN) begin
            cnt_d  = cnt_q + 8'd1;
`ifdef SPI_ADC_RAMP_EN
            ramp_d = ramp_q + DATA_BITS'(1);
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (fall_cnt_q != FALL_MAX) fall_cnt_d = fall_cnt_q + CNT_W'(1);
          bit_idx_d = idx_next;
          sdata_d   = frame_bit(shreg_q, idx_next);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (cs_fall) pend_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      fall_cnt_q <= '0;
      sdata_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      ready_q    <= '0;
      armed_q    <= 1'b0;
`ifdef SPI_ADC_RAMP_EN
      ramp_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      fall_cnt_q <= fall_cnt_d;
      sdata_q    <= sdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      // The synchronizer comes out of reset at "cs_n high"; only after it has
      // refilled from the pin can a high level be trusted. Arming on a real
      // high level stops a cs_n held low across reset from looking like a
      // fresh frame start.
      ready_q    <= {ready_q[0], 1'b1};
      armed_q    <= armed_q | (ready_q[1] & cs_lvl);
`ifdef SPI_ADC_RAMP_EN
      ramp_q     <= ramp_d;
`endif
    end
  end

  assign spi.sdata  = sdata_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign frame_cnt  = cnt_q;

endmodule : spi_slave_adc

// File: tb/tb_spi_slave_adc.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_adc
//   Drives spi_slave_adc as a bus master would (sclk idles low, sdata captured
//   just before each rising sclk). Each frame pushes its expected received
//   word and counter/flag state into a queue; a monitor pops and compares when
//   frame_done pulses.
// -----------------------------------------------------------------------------
module tb_spi_slave_adc;

  localparam int LZ = 3;
  localparam int DB = 8;
  localparam int FB = 16;
  localparam int HALF = 5;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sample_in;
  logic       busy, frame_done, frame_err;
  logic [7:0] frame_cnt;

  spi_slave_adc_if spi_if ();

  spi_slave_adc dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi_if),
    .sample_in  (sample_in),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rx_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pos_cnt = 0;
  int   rise_cyc = 0;

  // Reference model state
  logic [7:0] model_cnt  = 8'd0;
  logic       model_err  = 1'b0;
  logic [7:0] model_ramp = 8'd0;

  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Converter frame rule: LZ zeros, sample MSB first, zeros for everything after.
  function automatic logic exp_bit(input logic [7:0] s, input int k);
    logic [7:0] t;
    if (k >= LZ && k < LZ + DB) begin
      t = s >> (LZ + DB - 1 - k);
      return t[0];
    end
    return 1'b0;
  endfunction

  task automatic push_expected(input logic [7:0] s, input int nbits);
    exp_t e;
    e.word = '0;
    for (int k = 0; k < nbits; k++) e.word = {e.word[30:0], exp_bit(s, k)};
    if (nbits >= FB - 1) begin
      model_cnt  = model_cnt + 8'd1;
      model_ramp = model_ramp + 8'd1;
    end else begin
      model_err = 1'b1;
    end
    e.cnt = model_cnt;
    e.err = model_err;
    exp_q.push_back(e);
  endtask

  // One chip-select frame with n sclk periods; gap = clk cycles cs_n stays
  // high afterwards. sample_in is changed to chg_val after fall number chg_at.
  task automatic run_frame(input logic [7:0] s, input int n, input int gap,
                           input int chg_at, input logic [7:0] chg_val);
    logic [7:0]  used;
    logic [31:0] rx;
`ifdef SPI_ADC_RAMP_EN
    used = model_ramp;
`else
    used = s;
`endif
    push_expected(used, n);
    sample_in   = s;
    spi_if.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_active", 32'(busy), 32'd1);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      rx = {rx[30:0], spi_if.sdata};
      spi_if.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_if.sclk = 1'b0;
      if (i + 1 == chg_at) sample_in = chg_val;
      repeat (HALF) @(negedge clk);
    end
    rx_q.push_back(rx);
    rise_cyc    = pos_cnt;
    spi_if.cs_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d frames still pending, expected 0", exp_q.size());
      exp_q.delete();
      rx_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic        prev_done = 1'b0;
  exp_t        mon_e;
  logic [31:0] mon_rx;

  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_width", 32'(frame_done), 32'd0);
      if (frame_done) begin
        if (exp_q.size() == 0 || rx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: frame_done with no frame pending (t=%0t)", $time);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_rx = rx_q.pop_front();
          check("rx_word",      mon_rx,              mon_e.word);
          check("frame_cnt",    32'(frame_cnt),      32'(mon_e.cnt));
          check("frame_err",    32'(frame_err),      32'(mon_e.err));
          check("done_latency", 32'(pos_cnt - rise_cyc), 32'd3);
          check("busy_off",     32'(busy),           32'd0);
          check("sdata_off",    32'(spi_if.sdata),   32'd0);
        end
      end
      prev_done = frame_done;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n, gap, sel, chg;

    rst         = 1'b1;
    spi_if.cs_n = 1'b1;
    spi_if.sclk = 1'b0;
    sample_in   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sdata",     32'(spi_if.sdata), 32'd0);
    check("rst_busy",      32'(busy),         32'd0);
    check("rst_done",      32'(frame_done),   32'd0);
    check("rst_err",       32'(frame_err),    32'd0);
    check("rst_frame_cnt", 32'(frame_cnt),    32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

`ifdef SPI_ADC_RAMP_EN
    for (int f = 0; f < 257; f++) run_frame(8'($urandom), FB, 4, -1, 8'h00);
    drain();
    check("ramp_wrap_cnt", 32'(frame_cnt), 32'd1);
`else
    // Directed cases
    run_frame(8'hA5, FB, 4, -1, 8'h00);
    run_frame(8'h00, FB, 4, -1, 8'h00);
    run_frame(8'hFF, FB, 6, -1, 8'h00);
    run_frame(8'h77, 7,  6, -1, 8'h00);     // short frame -> sticky error
    run_frame(8'h3C, FB, 6, -1, 8'h00);
    run_frame(8'h12, FB, 6, 5, 8'hED);      // mid-frame sample change ignored
    run_frame(8'h81, FB - 1, 6, -1, 8'h00); // shortest good frame
    run_frame(8'h5A, FB - 2, 6, -1, 8'h00); // longest bad frame
    run_frame(8'hC3, FB + 2, 6, -1, 8'h00); // extra falls read trailing zeros
    run_frame(8'h96, FB, 1, -1, 8'h00);     // next cs_fall lands in DONE
    run_frame(8'h69, FB, 6, -1, 8'h00);
    drain();

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      n = FB;
      else if (sel == 6) n = FB - 1;
      else if (sel == 7) n = FB - 2;
      else if (sel == 8) n = $urandom_range(0, FB - 3);
      else               n = $urandom_range(FB + 1, FB + 2);
      gap = $urandom_range(1, 8);
      chg = $urandom_range(1, 12);
      run_frame(8'($urandom), n, gap, chg, 8'($urandom));
    end
    repeat (6) @(negedge clk);
    drain();
`endif

    // Reset in the middle of a frame
    sample_in   = 8'hE7;
    spi_if.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      spi_if.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_if.sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("abort_sdata",     32'(spi_if.sdata), 32'd0);
    check("abort_busy",      32'(busy),         32'd0);
    check("abort_done",      32'(frame_done),   32'd0);
    check("abort_err",       32'(frame_err),    32'd0);
    check("abort_frame_cnt", 32'(frame_cnt),    32'd0);
    model_cnt  = 8'd0;
    model_err  = 1'b0;
    model_ramp = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    // cs_n still low: not a fresh falling edge, so no frame may start.
    repeat (10) @(negedge clk);
    check("no_start_held_cs", 32'(busy), 32'd0);
    spi_if.cs_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      spi_if.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_if.sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      check("no_busy_cs_high", 32'(busy), 32'd0);
    end
    run_frame(8'h5A, FB, 6, -1, 8'h00);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_spi_slave_adc
